// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with memory handshake, retire counter and traps
//  Ports: clk, rst (sync, active-high); opcode/funct from IR; zero from ALU; mem_ready from memory.
//   Controls: pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, reg_dst,
//   alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_source[1:0].
//   Status: state[3:0] (debug), illegal/timeout (sticky traps), instr_count[CNT_W-1:0].
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam int WW = $clog2(WAIT_MAX + 2);

    state_t stateQ, nextState;
    logic [WW-1:0] waitCnt;
    logic retire, setIllegal, setTimeout, waitExpired, legalFunct, isMem;

    assign state = stateQ;
    // The current cycle is the last allowed waiting cycle; a low mem_ready now means timeout.
    assign waitExpired = (WAIT_MAX != 0) && (waitCnt == WW'(WAIT_MAX - 1));
    assign legalFunct = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    assign isMem = stateQ inside {FETCH, MEMRD, MEMWR};

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= FETCH;
            instr_count <= '0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            waitCnt     <= '0;
        end else begin
            stateQ <= nextState;
            if (retire) instr_count <= instr_count + CNT_W'(1);
            if (setIllegal) illegal <= 1'b1;
            if (setTimeout) timeout <= 1'b1;
            // Any state change clears the count, so each wait state starts fresh on entry.
            waitCnt <= (nextState != stateQ) ? '0 : (isMem && !mem_ready) ? waitCnt + WW'(1) : waitCnt;
        end
    end

    always_comb begin
        nextState  = stateQ;
        retire     = 1'b0;
        setIllegal = 1'b0;
        setTimeout = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 3'd0;
        pc_source  = 2'd0;
        case (stateQ)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) nextState = DECODE;
                else if (waitExpired) begin
                    nextState  = TRAP;
                    setTimeout = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b = 2'd3;
                if (opcode == 6'h23 || opcode == 6'h2B) nextState = MEMADR;
                else if (opcode == 6'h00 && legalFunct) nextState = EXEC;
                else if (opcode == 6'h04) nextState = BRANCH;
                else if (opcode == 6'h08) nextState = ADDIEX;
                else if (opcode == 6'h02) nextState = JUMP;
                else begin
                    nextState  = TRAP;
                    setIllegal = 1'b1;
                end
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (opcode == 6'h23) nextState = MEMRD;
                else if (opcode == 6'h2B) nextState = MEMWR;
                else begin
                    nextState  = TRAP;
                    setIllegal = 1'b1;
                end
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) nextState = MEMWB;
                else if (waitExpired) begin
                    nextState  = TRAP;
                    setTimeout = 1'b1;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nextState  = FETCH;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    nextState = FETCH;
                    retire    = 1'b1;
                end else if (waitExpired) begin
                    nextState  = TRAP;
                    setTimeout = 1'b1;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = (funct == 6'h22) ? 3'd1 : (funct == 6'h24) ? 3'd2 :
                            (funct == 6'h25) ? 3'd3 : (funct == 6'h2A) ? 3'd4 : 3'd0;
                nextState = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nextState = FETCH;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'd1;
                pc_source = 2'd1;
                pc_write  = zero;
                nextState = FETCH;
                retire    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                nextState = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                nextState = FETCH;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_source = 2'd2;
                pc_write  = 1'b1;
                nextState = FETCH;
                retire    = 1'b1;
            end
            TRAP: nextState = TRAP;
            default: begin
                nextState  = TRAP;
                setIllegal = 1'b1;
            end
        endcase
        // Reset overrides everything so no write can slip out during the reset cycle.
        if (rst) begin
            {pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, reg_dst} = 8'd0;
            {alu_src_a, alu_src_b, alu_op, pc_source} = 8'd0;
        end
    end
endmodule
